// File: rtl/fixmul_pkg.sv
// Shared constants and saturation-limit helpers for the fixed-point multiplier.
package fixmul_pkg;

  localparam int unsigned ROUND_TRUNC   = 0;
  localparam int unsigned ROUND_NEAREST = 1;

  // Wide enough for any supported OUT_BITS; callers cast down to their own width.
  localparam int unsigned LIMIT_BITS = 160;
  typedef logic [LIMIT_BITS-1:0] limit_t;

  // Largest positive magnitude of a signed field of the given width.
  function automatic limit_t sat_max_mag(input int unsigned bits);
    limit_t one;
    one = limit_t'(1);
    return (one << (bits - 1)) - one;
  endfunction

  // Magnitude of the most negative value of a signed field of the given width.
  function automatic limit_t sat_min_mag(input int unsigned bits);
    return limit_t'(1) << (bits - 1);
  endfunction

endpackage

// File: rtl/fixmul_pipe_if.sv
// Operand/result handshake bundle for fixmul_pipe.
interface fixmul_pipe_if #(
  parameter int unsigned IN_BITS  = 37,
  parameter int unsigned OUT_BITS = 37
);

  logic                in_valid;
  logic                in_ready;
  logic [IN_BITS-1:0]  a;
  logic [IN_BITS-1:0]  b;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] result;
  logic                ovf;
  logic                ovf_sticky;
  logic                ovf_clear;

  modport master (
    output in_valid, a, b, out_ready, ovf_clear,
    input  in_ready, out_valid, result, ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, a, b, out_ready, ovf_clear,
    output in_ready, out_valid, result, ovf, ovf_sticky
  );

endinterface

// File: rtl/fixmul_round_sat.sv
// Combinational scaling (truncate or round half away from zero) and saturation of a
// sign/magnitude product into a signed OUT_BITS result.
module fixmul_round_sat
  import fixmul_pkg::*;
#(
  parameter int unsigned OUT_BITS  = 37,
  parameter int unsigned FRAC_BITS = 35,
  parameter int unsigned ROUND     = ROUND_TRUNC,
  parameter int unsigned IN_BITS   = 37
) (
  input  logic [2*IN_BITS-1:0] prod,
  input  logic                 neg,
  output logic [OUT_BITS-1:0]  result,
  output logic                 ovf
);

  localparam int unsigned PW = 2 * IN_BITS;
  // One spare bit for the rounding carry, and never narrower than the result plus sign.
  localparam int unsigned CW = (PW + 1 > OUT_BITS + 1) ? PW + 1 : OUT_BITS + 1;
  localparam int unsigned HALF_POS = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;

  localparam logic [CW-1:0] MAX_POS = CW'(sat_max_mag(OUT_BITS));
  localparam logic [CW-1:0] MAX_NEG = CW'(sat_min_mag(OUT_BITS));
  localparam logic [CW-1:0] HALF    = (ROUND == ROUND_NEAREST && FRAC_BITS > 0) ?
                                      (CW'(1) << HALF_POS) : '0;

  logic [CW-1:0] mag;

  // Scale the magnitude; rounding on the magnitude gives symmetric behaviour about zero.
  always_comb begin
    mag = (CW'(prod) + HALF) >> FRAC_BITS;
  end

  // Saturate against the signed limits and restore the sign; -0 naturally yields all zeros.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    if (!neg) begin
      if (mag > MAX_POS) begin
        result = OUT_BITS'(MAX_POS);
        ovf    = 1'b1;
      end else begin
        result = OUT_BITS'(mag);
      end
    end else begin
      if (mag > MAX_NEG) begin
        result = OUT_BITS'(MAX_NEG);
        ovf    = 1'b1;
      end else begin
        result = OUT_BITS'(~mag + CW'(1));
      end
    end
  end

endmodule

// File: rtl/fixmul_pipe.sv
// Pipelined signed fixed-point multiplier: operand register, multiply (plus optional
// extra stages), round/saturate register. A single global stall freezes all stages.
module fixmul_pipe
  import fixmul_pkg::*;
#(
  parameter int unsigned IN_BITS      = 37,
  parameter int unsigned OUT_BITS     = 37,
  parameter int unsigned FRAC_BITS    = 35,
  parameter int unsigned EXTRA_STAGES = 0,
  parameter int unsigned ROUND        = ROUND_TRUNC
) (
  input logic          clk,
  input logic          reset,
  fixmul_pipe_if.slave bus
);

  localparam int unsigned PW   = 2 * IN_BITS;
  localparam int unsigned NMUL = EXTRA_STAGES + 1;

  logic stall;

  logic [IN_BITS-1:0] mag_a, mag_b;
  logic               op_vld_q, op_neg_q;
  logic [IN_BITS-1:0] mag_a_q, mag_b_q;

  logic          mul_vld_q  [NMUL];
  logic          mul_neg_q  [NMUL];
  logic [PW-1:0] mul_prod_q [NMUL];

  logic [OUT_BITS-1:0] rs_result;
  logic                rs_ovf;

  logic                out_vld_q, ovf_q;
  logic [OUT_BITS-1:0] result_q;
  logic                sticky_q, sticky_d;

  assign stall = out_vld_q && !bus.out_ready;

  // Operand magnitudes; the most negative value maps to 2^(IN_BITS-1) as unsigned.
  always_comb begin
    mag_a = bus.a[IN_BITS-1] ? (~bus.a + IN_BITS'(1)) : bus.a;
    mag_b = bus.b[IN_BITS-1] ? (~bus.b + IN_BITS'(1)) : bus.b;
  end

  // Operand stage: register magnitudes and product sign.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_vld_q <= 1'b0;
      op_neg_q <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
    end else if (!stall) begin
      op_vld_q <= bus.in_valid;
      op_neg_q <= bus.a[IN_BITS-1] ^ bus.b[IN_BITS-1];
      mag_a_q  <= mag_a;
      mag_b_q  <= mag_b;
    end
  end

  // Multiply stage plus EXTRA_STAGES retiming registers behind it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NMUL; i++) begin
        mul_vld_q[i]  <= 1'b0;
        mul_neg_q[i]  <= 1'b0;
        mul_prod_q[i] <= '0;
      end
    end else if (!stall) begin
      mul_vld_q[0]  <= op_vld_q;
      mul_neg_q[0]  <= op_neg_q;
      mul_prod_q[0] <= PW'(mag_a_q) * PW'(mag_b_q);
      for (int i = 1; i < NMUL; i++) begin
        mul_vld_q[i]  <= mul_vld_q[i-1];
        mul_neg_q[i]  <= mul_neg_q[i-1];
        mul_prod_q[i] <= mul_prod_q[i-1];
      end
    end
  end

  fixmul_round_sat #(
    .OUT_BITS  (OUT_BITS),
    .FRAC_BITS (FRAC_BITS),
    .ROUND     (ROUND),
    .IN_BITS   (IN_BITS)
  ) u_round_sat (
    .prod   (mul_prod_q[NMUL-1]),
    .neg    (mul_neg_q[NMUL-1]),
    .result (rs_result),
    .ovf    (rs_ovf)
  );

  // Round/saturate stage: holds the presented result until downstream takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
    end else if (!stall) begin
      out_vld_q <= mul_vld_q[NMUL-1];
      ovf_q     <= mul_vld_q[NMUL-1] && rs_ovf;
      result_q  <= rs_result;
    end
  end

  // Sticky overflow: a transferred overflow beats a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (bus.ovf_clear) begin
      sticky_d = 1'b0;
    end
    if (out_vld_q && bus.out_ready && ovf_q) begin
      sticky_d = 1'b1;
    end
  end

  // Sticky overflow register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign bus.in_ready   = !stall;
  assign bus.out_valid  = out_vld_q;
  assign bus.result     = result_q;
  assign bus.ovf        = ovf_q;
  assign bus.ovf_sticky = sticky_q;

endmodule
